seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Receive-side companion to the 3-bit sequence counter (`sc`).
- Samples the counter's q/count stream, locks onto the wrapping 0..LAST sequence, and verifies every step and every wrap flag.
- Counts completed sequences and detected errors.
- Sits downstream of the counter as an on-chip checker. Bench and silicon both use it to prove the generator is healthy.

Parameters:
- WIDTH, 3, width of the sequence value d.
- LAST, 7, terminal value; expected successor of LAST is 0.
- LOCK_N, 2, consecutive correct samples required to declare lock (≥1).
- CNT_W, 8, width of seq_cnt and err_cnt.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous clear: return to HUNT, zero both counters.
- vld  input  1  d/count are sampled only when vld=1.
- d  input  WIDTH  sequence value (generator q).
- count  input  1  wrap flag; must be 1 exactly when d==LAST.
- locked  output  1  1 while in LOCK.
- err  output  1  error indication (see Optional Feature).
- exp  output  WIDTH  next expected value.
- seq_cnt  output  CNT_W  completed sequences seen while locked.
- err_cnt  output  CNT_W  errors detected, saturating.

Behaviour:
- Reset (rst=0, async): state=HUNT, locked=0, err=0, exp=0, seq_cnt=0, err_cnt=0, internal run count=0.
- All outputs are registered and update on the edge that samples vld=1, so they are visible the following cycle.
- Definitions:
  - nxt(x) = (x==LAST) ? 0 : x+1.
  - A sample is good when d==exp, d≤LAST, and count==(d==LAST).
- HUNT:
  - On vld with d≤LAST: exp←nxt(d), run←1.
  - If LOCK_N==1, go to LOCK; otherwise go to SYNC.
  - On vld with d>LAST: stay in HUNT. No error is raised.
- SYNC:
  - On a good sample: run++, exp←nxt(d). When run reaches LOCK_N, go to LOCK.
  - On a bad sample: resynchronise on it (exp←nxt(d), run←1) and stay in SYNC. No error is raised in SYNC.
  - If a bad sample has d>LAST, go to HUNT instead.
- LOCK:
  - On a good sample: exp←nxt(d).
  - If a good sample has d==LAST, seq_cnt increments. seq_cnt wraps modulo 2^CNT_W.
  - On a bad sample (value mismatch, d>LAST, or wrong count flag): err asserted, err_cnt increments (saturating at all-ones), locked←0, state←ERR, exp unchanged.
- ERR:
  - On the next vld sample, behave exactly as HUNT.
  - No sample taken in ERR can raise a further error.
- vld=0: no state, counter or exp change.
- clr=1: state←HUNT, seq_cnt←0, err_cnt←0, err←0, exp←0.
  - clr has priority over a simultaneous vld.
- Reset mid-sequence: everything returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SEQ_CHECKER_STICKY_ERR_EN.
- Defined:
  - err is sticky: set on the first LOCK error.
  - Held through relock until clr or rst.
- Not defined:
  - err is a one-cycle pulse, high only in the cycle after the erroring sample.
- Both builds:
  - err_cnt counts every error identically.

Test Plan:
- Clean stream: rst low 10 ns then high; drive 0,1,...,7 with count=1 on 7, repeated 3 times.
  - locked=1 after the 2nd sample.
  - seq_cnt=3; err_cnt=0; err never 1.
- Skip: while locked, drive 3 then 5.
  - err=1 one cycle after 5; err_cnt=1; locked=0; exp stays 4.
  - Then drive 6,7 → locked=1 again.
- Missing wrap flag: while locked, drive d=7 with count=0.
  - err_cnt increments; seq_cnt unchanged.
  - Separately, count=1 with d=4 → error.
- Gaps and clear:
  - Gapped stream (vld toggling) → identical counts to the clean stream.
  - clr and vld high together at d=0 → state HUNT, counters 0, exp=0.
  - Next vld with d=1 → exp=2.
- Reset and saturation:
  - Async rst asserted mid-cycle while locked → all outputs 0 before the next edge.
  - With CNT_W=2, five forced errors → err_cnt=3.
- Optional feature:
  - Macro defined: after one error and relock, err stays 1 until clr.
  - Macro undefined: err is high for exactly one cycle.

Source files
------------

// File: rtl/seq_checker.sv
// Receive-side checker for the wrapping 0..LAST sequence counter stream.
// Define SEQ_CHECKER_STICKY_ERR_EN to make err hold until clr/rst instead of pulsing.
module seq_checker #(
  parameter int WIDTH  = 3,
  parameter int LAST   = 7,
  parameter int LOCK_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vld,
  input  logic [WIDTH-1:0] d,
  input  logic             count,
  output logic             locked,
  output logic             err,
  output logic [WIDTH-1:0] exp,
  output logic [CNT_W-1:0] seq_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK, ERR} state_t;

  state_t           state;
  logic [RUN_W-1:0] run;
  logic             in_rng;
  logic             is_last;
  logic             good;
  logic             lock_err;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return (x == LAST_V) ? '0 : x + WIDTH'(1);
  endfunction

  // Range check done in int so narrow d never folds into a constant compare.
  assign in_rng   = (int'(d) <= LAST);
  assign is_last  = (d == LAST_V);
  assign good     = in_rng && (d == exp) && (count == is_last);
  assign lock_err = vld && (state == LOCK) && !good;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HUNT;
      run     <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      exp     <= '0;
      seq_cnt <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      state   <= HUNT;
      run     <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      exp     <= '0;
      seq_cnt <= '0;
      err_cnt <= '0;
    end else begin
`ifdef SEQ_CHECKER_STICKY_ERR_EN
      err <= err | lock_err;
`else
      err <= lock_err;
`endif
      if (vld) begin
        case (state)
          // ERR re-acquires exactly like HUNT; out-of-range values are ignored.
          HUNT, ERR: begin
            if (in_rng) begin
              exp <= nxt(d);
              run <= RUN_W'(1);
              if (LOCK_N <= 1) begin
                state  <= LOCK;
                locked <= 1'b1;
              end else begin
                state <= SYNC;
              end
            end else begin
              state <= HUNT;
            end
          end
          SYNC: begin
            if (good) begin
              run <= run + RUN_W'(1);
              exp <= nxt(d);
              if (int'(run) + 1 >= LOCK_N) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else if (!in_rng) begin
              state <= HUNT;
            end else begin
              exp <= nxt(d);
              run <= RUN_W'(1);
            end
          end
          LOCK: begin
            if (good) begin
              exp <= nxt(d);
              if (is_last) seq_cnt <= seq_cnt + CNT_W'(1);
            end else begin
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
              locked <= 1'b0;
              state  <= ERR;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Randomized and directed bench for seq_checker against a behavioural stream model.
module tb_seq_checker;

  localparam int LAST   = 7;
  localparam int LOCK_N = 2;
`ifdef SEQ_CHECKER_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr, vld, count;
  logic [2:0] d;
  logic       locked, err, locked2, err2;
  logic [2:0] exp, exp2;
  logic [7:0] seq_cnt, err_cnt;
  logic [1:0] seq_cnt2, err_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: "have" = a reference value is held; locked implies have.
  bit m_locked, m_have, m_err;
  int m_exp, m_run, m_seq, m_ecnt, m_seq2, m_ecnt2;

  always #5 clk = ~clk;

  seq_checker #(.WIDTH(3), .LAST(LAST), .LOCK_N(LOCK_N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .d(d), .count(count),
    .locked(locked), .err(err), .exp(exp), .seq_cnt(seq_cnt), .err_cnt(err_cnt));

  seq_checker #(.WIDTH(3), .LAST(LAST), .LOCK_N(LOCK_N), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .d(d), .count(count),
    .locked(locked2), .err(err2), .exp(exp2), .seq_cnt(seq_cnt2), .err_cnt(err_cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int nxt(input int x);
    return (x == LAST) ? 0 : x + 1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_err = 0;
    m_exp = 0; m_run = 0; m_seq = 0; m_ecnt = 0; m_seq2 = 0; m_ecnt2 = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input int dd, input bit cf);
    bit ev;
    bit good;
    ev = 0;
    if (c) begin
      model_reset();
      return;
    end
    if (v) begin
      good = (dd == m_exp) && (dd <= LAST) && (cf == (dd == LAST));
      if (m_locked) begin
        if (good) begin
          m_exp = nxt(dd);
          if (dd == LAST) begin
            m_seq  = (m_seq + 1) % 256;
            m_seq2 = (m_seq2 + 1) % 4;
          end
        end else begin
          ev = 1;
          if (m_ecnt < 255) m_ecnt++;
          if (m_ecnt2 < 3) m_ecnt2++;
          m_locked = 0;
          m_have   = 0;
        end
      end else if (!m_have) begin
        if (dd <= LAST) begin
          m_exp = nxt(dd); m_run = 1; m_have = 1;
          m_locked = (m_run >= LOCK_N);
        end
      end else if (good) begin
        m_run++;
        m_exp = nxt(dd);
        if (m_run >= LOCK_N) m_locked = 1;
      end else if (dd > LAST) begin
        m_have = 0;
      end else begin
        m_exp = nxt(dd); m_run = 1;
      end
    end
    m_err = STICKY ? (m_err | ev) : ev;
  endtask

  task automatic check_all();
    check("locked", locked, m_locked);
    check("err", err, m_err);
    check("exp", exp, m_exp);
    check("seq_cnt", seq_cnt, m_seq);
    check("err_cnt", err_cnt, m_ecnt);
    check("seq_cnt_w2", seq_cnt2, m_seq2);
    check("err_cnt_w2", err_cnt2, m_ecnt2);
  endtask

  task automatic step(input bit c, input bit v, input int dd, input bit cf);
    @(negedge clk);
    clr = c; vld = v; d = 3'(dd); count = cf;
    @(posedge clk);
    model_step(c, v, dd, cf);
    #1 check_all();
  endtask

  task automatic sample(input int dd);
    step(0, 1, dd, dd == LAST);
  endtask

  task automatic idle();
    step(0, 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int g;
    rst = 1'b0; clr = 1'b0; vld = 1'b0; d = '0; count = 1'b0;
    model_reset();
    #1 check_all();
    #9 rst = 1'b1;

    // Clean stream, three full sequences
    for (int r = 0; r < 3; r++)
      for (int i = 0; i <= LAST; i++) begin
        sample(i);
        if (r == 0 && i == 0) check("lock_after_1", locked, 0);
        if (r == 0 && i == 1) check("lock_after_2", locked, 1);
      end
    check("clean_seq", seq_cnt, 3);
    check("clean_err", err_cnt, 0);

    // Skip 4 while locked
    for (int i = 0; i <= 3; i++) sample(i);
    sample(5);
    check("skip_err", err, 1);
    check("skip_errcnt", err_cnt, 1);
    check("skip_locked", locked, 0);
    check("skip_exp", exp, 4);
    sample(6);
    sample(7);
    check("skip_relock", locked, 1);
    idle();
    check("err_after_relock", err, STICKY ? 1 : 0);

    // Missing wrap flag, then spurious wrap flag
    for (int i = 0; i < LAST; i++) sample(i);
    step(0, 1, 7, 0);
    check("nowrap_errcnt", err_cnt, 2);
    check("nowrap_seq", seq_cnt, 3);
    for (int i = 0; i <= 3; i++) sample(i);
    step(0, 1, 4, 1);
    check("badwrap_errcnt", err_cnt, 3);

    // Clear with simultaneous vld
    step(1, 1, 0, 0);
    check("clr_locked", locked, 0);
    check("clr_seq", seq_cnt, 0);
    check("clr_errcnt", err_cnt, 0);
    check("clr_exp", exp, 0);
    check("clr_err", err, 0);
    sample(1);
    check("post_clr_exp", exp, 2);

    // Gapped stream with garbage on idle cycles
    step(1, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i <= LAST; i++) begin
        if ($urandom_range(0, 1) == 1) idle();
        sample(i);
      end
    check("gap_seq", seq_cnt, 3);
    check("gap_err", err_cnt, 0);

    // Asynchronous reset between edges while locked
    check("pre_rst_locked", locked, 1);
    vld = 1'b0; clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_exp", exp, 0);
    check("rst_seq", seq_cnt, 0);
    model_reset();
    check_all();
    @(negedge clk) rst = 1'b1;

    // Five forced errors: narrow counter saturates
    for (int k = 0; k < 5; k++) begin
      sample(0);
      sample(1);
      step(0, 1, 5, 0);
    end
    check("sat_w8", err_cnt, 5);
    check("sat_w2", err_cnt2, 3);

    // Randomized stream with corruptions, gaps and rare clears
    g = 0;
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 0);
      else if (r < 25) idle();
      else if (r < 31) step(0, 1, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else if (r < 34) step(0, 1, g, g != LAST);
      else begin
        sample(g);
        g = nxt(g);
      end
      if (r == 99) g = $urandom_range(0, LAST);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
